// File: rtl/rf_writeback.sv
// rf_writeback: stage-3 writeback unit driving the register-file write port.
//
// Accepts either a finished ALU result or a load request. Loads wait for the
// data-memory response, then get aligned and sign/zero-extended. The write
// register (rd/wb_data/we) is held while stall=1 and consumed at every
// non-stalled edge. A one-entry forwarding path exposes the pending write to
// the stage-1 read ports.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   stall                global pipeline stall (freezes write register, blocks accept)
//   in_valid, in_rd, in_we, in_is_load, in_funct3, in_addr_lo, in_alu
//                        stage-3 instruction
//   mem_rvalid, mem_rdata
//                        data-memory read response
//   rs1, rs2             stage-1 read indices for forwarding compare
//   rd, wb_data, we      registered register-file write port
//   load_stall           high while a load is outstanding
//   fwd1_hit/data, fwd2_hit/data
//                        forwarding of the pending write
module rf_writeback (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        in_valid,
   input  logic [4:0]  in_rd,
   input  logic        in_we,
   input  logic        in_is_load,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_alu,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic [31:0] wb_data,
   output logic        we,
   output logic        load_stall,
   output logic        fwd1_hit,
   output logic        fwd2_hit,
   output logic [31:0] fwd1_data,
   output logic [31:0] fwd2_data
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t      state_q, state_d;
   logic [4:0]  ld_rd_q, ld_rd_d;
   logic [2:0]  ld_f3_q, ld_f3_d;
   logic [1:0]  ld_lo_q, ld_lo_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        we_q, we_d;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   always_comb begin
      ld_byte = 8'(mem_rdata >> {ld_lo_q, 3'b000});
      ld_half = ld_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (ld_f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end
   always_comb begin
      state_d   = state_q;
      ld_rd_d   = ld_rd_q;
      ld_f3_d   = ld_f3_q;
      ld_lo_d   = ld_lo_q;
      rd_d      = rd_q;
      wb_data_d = wb_data_q;
      // a non-stalled edge always consumes the pending write
      we_d      = stall ? we_q : 1'b0;
      if (state_q == IDLE) begin
         if (in_valid && !stall) begin
            if (in_is_load) begin
               state_d = WAIT;
               ld_rd_d = in_rd;
               ld_f3_d = in_funct3;
               ld_lo_d = in_addr_lo;
            end else if (in_we && in_rd != 5'd0) begin
               rd_d      = in_rd;
               wb_data_d = in_alu;
               we_d      = 1'b1;
            end
         end
      end else if (mem_rvalid) begin
         // the write register is empty in WAIT, so the response may land even when stalled
         state_d = IDLE;
         if (ld_rd_q != 5'd0) begin
            rd_d      = ld_rd_q;
            wb_data_d = ld_data;
            we_d      = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ld_rd_q   <= 5'd0;
         ld_f3_q   <= 3'd0;
         ld_lo_q   <= 2'd0;
         rd_q      <= 5'd0;
         wb_data_q <= 32'd0;
         we_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_rd_q   <= ld_rd_d;
         ld_f3_q   <= ld_f3_d;
         ld_lo_q   <= ld_lo_d;
         rd_q      <= rd_d;
         wb_data_q <= wb_data_d;
         we_q      <= we_d;
      end
   end
   assign rd         = rd_q;
   assign wb_data    = wb_data_q;
   assign we         = we_q;
   assign load_stall = state_q == WAIT;
   assign fwd1_hit   = we_q && rd_q == rs1 && rd_q != 5'd0;
   assign fwd2_hit   = we_q && rd_q == rs2 && rd_q != 5'd0;
   assign fwd1_data  = wb_data_q;
   assign fwd2_data  = wb_data_q;
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: scoreboard bench for rf_writeback with directed and random stimulus.
module tb_rf_writeback;
   logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0;
   logic        in_valid = 1'b0, in_we = 1'b0, in_is_load = 1'b0, mem_rvalid = 1'b0;
   logic [4:0]  in_rd = '0, rs1 = '0, rs2 = '0;
   logic [2:0]  in_funct3 = '0;
   logic [1:0]  in_addr_lo = '0;
   logic [31:0] in_alu = '0, mem_rdata = '0;
   logic [4:0]  rd;
   logic [31:0] wb_data, fwd1_data, fwd2_data;
   logic        we, load_stall, fwd1_hit, fwd2_hit;
   int chk_cnt = 0, pass_cnt = 0;
   typedef struct packed {logic [4:0] rd; logic [31:0] d;} wr_t;
   wr_t exp_q[$];
   wr_t e;
   rf_writeback dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .in_valid(in_valid), .in_rd(in_rd),
      .in_we(in_we), .in_is_load(in_is_load), .in_funct3(in_funct3), .in_addr_lo(in_addr_lo),
      .in_alu(in_alu), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rs1(rs1), .rs2(rs2),
      .rd(rd), .wb_data(wb_data), .we(we), .load_stall(load_stall), .fwd1_hit(fwd1_hit),
      .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
   );
   always #5 clk = ~clk;
   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   function automatic logic [31:0] model(logic [2:0] f3, logic [1:0] lo, logic [31:0] w);
      longint v;
      int byte_n = int'(lo);
      int half_n = int'(lo) / 2;
      case (f3)
         3'b000, 3'b100: begin
            v = (longint'(w) / (longint'(1) << (8 * byte_n))) % 256;
            if (f3 == 3'b000 && v > 127) v -= 256;
         end
         3'b001, 3'b101: begin
            v = (longint'(w) / (longint'(1) << (16 * half_n))) % 65536;
            if (f3 == 3'b001 && v > 32767) v -= 65536;
         end
         default: v = longint'(w);
      endcase
      return v[31:0];
   endfunction
   // a write is committed at the next edge when we=1 and stall=0
   always @(negedge clk) begin
      if (reset_n && we === 1'b1 && stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL unexpected_write: got rd=%0d data=%h expected no write", rd, wb_data);
         end else begin
            e = exp_q.pop_front();
            check("wb_rd", 32'(rd), 32'(e.rd));
            check("wb_data", wb_data, e.d);
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic alu_op(logic [4:0] r, logic w, logic [31:0] d);
      in_valid = 1'b1; in_is_load = 1'b0; in_we = w; in_rd = r; in_alu = d; stall = 1'b0;
      if (w && r != 5'd0) exp_q.push_back('{rd: r, d: d});
      step();
      in_valid = 1'b0;
   endtask
   task automatic load_op(logic [4:0] r, logic [2:0] f3, logic [1:0] lo, logic [31:0] w,
                          int dly, logic rsp_stall);
      int ls = 0;
      in_valid = 1'b1; in_is_load = 1'b1; in_rd = r; in_funct3 = f3; in_addr_lo = lo; stall = 1'b0;
      step();
      in_is_load = 1'b0;
      repeat (dly) begin
         if (load_stall) ls++;
         in_valid = 1'($urandom_range(0, 1)); in_we = 1'b1;
         in_rd = 5'($urandom_range(1, 31)); in_alu = $urandom;
         stall = 1'($urandom_range(0, 1));
         step();
      end
      if (load_stall) ls++;
      in_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = w; stall = rsp_stall;
      if (r != 5'd0) exp_q.push_back('{rd: r, d: model(f3, lo, w)});
      step();
      mem_rvalid = 1'b0;
      check("load_stall_done", 32'(load_stall), 32'd0);
      check("load_stall_cycles", ls, dly + 1);
   endtask
   typedef struct {logic [2:0] f3; logic [1:0] lo; logic [31:0] exp;} vec_t;
   vec_t vecs[5] = '{'{3'b000, 2'd2, 32'hFFFFFFF1}, '{3'b100, 2'd3, 32'h00000080},
                     '{3'b001, 2'd0, 32'h00007F42}, '{3'b101, 2'd2, 32'h000080F1},
                     '{3'b010, 2'd1, 32'h80F17F42}};
   initial begin
      #2;
      check("rst_we", 32'(we), 32'd0);
      check("rst_rd", 32'(rd), 32'd0);
      check("rst_wb_data", wb_data, 32'd0);
      check("rst_load_stall", 32'(load_stall), 32'd0);
      check("rst_fwd1_hit", 32'(fwd1_hit), 32'd0);
      @(posedge clk); #1; reset_n = 1'b1;
      step();
      alu_op(5'd5, 1'b1, 32'h1234);
      check("b2b_we1", 32'(we), 32'd1);
      check("b2b_rd1", 32'(rd), 32'd5);
      alu_op(5'd6, 1'b1, 32'hABCD);
      check("b2b_we2", 32'(we), 32'd1);
      check("b2b_data2", wb_data, 32'hABCD);
      alu_op(5'd0, 1'b1, 32'h7777);
      check("rd0_we", 32'(we), 32'd0);
      foreach (vecs[i]) begin
         load_op(5'd10 + 5'(i), vecs[i].f3, vecs[i].lo, 32'h80F17F42, i % 3, 1'b0);
         check("align_we", 32'(we), 32'd1);
         check("align_data", wb_data, vecs[i].exp);
      end
      load_op(5'd12, 3'b010, 2'd0, 32'h0BADF00D, 2, 1'b0);
      alu_op(5'd7, 1'b1, 32'h55);
      stall = 1'b1;
      repeat (4) begin
         check("hold_we", 32'(we), 32'd1);
         check("hold_rd", 32'(rd), 32'd7);
         check("hold_data", wb_data, 32'h55);
         step();
      end
      stall = 1'b0;
      step();
      check("clr_we", 32'(we), 32'd0);
      check("clr_rd", 32'(rd), 32'd7);
      check("clr_data", wb_data, 32'h55);
      load_op(5'd13, 3'b001, 2'd3, 32'h8001_0000, 1, 1'b1);
      check("rsp_stall_we", 32'(we), 32'd1);
      check("rsp_stall_data", wb_data, 32'hFFFF8001);
      step();
      check("rsp_stall_hold", wb_data, 32'hFFFF8001);
      stall = 1'b0;
      step();
      alu_op(5'd9, 1'b1, 32'h9999);
      rs1 = 5'd9; rs2 = 5'd8; #1;
      check("fwd1_hit", 32'(fwd1_hit), 32'd1);
      check("fwd1_data", fwd1_data, 32'h9999);
      check("fwd2_hit", 32'(fwd2_hit), 32'd0);
      alu_op(5'd0, 1'b1, 32'h1111);
      rs1 = 5'd0; rs2 = 5'd0; #1;
      check("fwd_rd0_hit1", 32'(fwd1_hit), 32'd0);
      check("fwd_rd0_hit2", 32'(fwd2_hit), 32'd0);
      alu_op(5'd3, 1'b1, 32'hDEAD);
      in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd4; in_funct3 = 3'b010;
      step();
      in_valid = 1'b0; in_is_load = 1'b0;
      step();
      #2 reset_n = 1'b0;
      #1;
      check("arst_load_stall", 32'(load_stall), 32'd0);
      check("arst_we", 32'(we), 32'd0);
      check("arst_data", wb_data, 32'd0);
      step();
      reset_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_rvalid = 1'b0;
      check("late_rvalid_we", 32'(we), 32'd0);
      for (int n = 0; n < 200; n++) begin
         case ($urandom_range(0, 3))
            0, 1: alu_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom);
            2: load_op(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                       $urandom, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
            default: begin
               in_valid = 1'b0;
               mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
               stall = 1'($urandom_range(0, 1));
               step();
               mem_rvalid = 1'b0;
            end
         endcase
      end
      stall = 1'b0;
      step();
      step();
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
